// File: rtl/ks_pkg.sv
// rtl/ks_pkg.sv - shared types and derived-depth helpers for the Kogge-Stone pipeline
package ks_pkg;

    // Generate/propagate pair carried through the prefix network
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int ks_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    function automatic int ks_levels(input int width);
        return ks_clog2(width);
    endfunction

    function automatic int ks_prefix_stages(input int width, input int lps);
        return (ks_clog2(width) + lps - 1) / lps;
    endfunction

    function automatic int ks_latency(input int width, input int lps);
        return ks_prefix_stages(width, lps) + 1;
    endfunction

endpackage

// File: rtl/ks_prefix_cell.sv
// rtl/ks_prefix_cell.sv - Kogge-Stone dot operator (combine a high and a low g/p span)
module ks_prefix_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g,
    output logic p
);

    assign g = g_hi | (p_hi & g_lo);
    assign p = p_hi & p_lo;

endmodule

// File: rtl/ks_adder_pipe.sv
// rtl/ks_adder_pipe.sv - pipelined Kogge-Stone add/sub with valid/ready flow control; KS_OVF_EN adds out_ovf
module ks_adder_pipe
    import ks_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int LEVELS_PER_STAGE = 2,
    parameter int TAG_WIDTH        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_cin,
    input  logic                  in_sub,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   out_sum,
    output logic [TAG_WIDTH-1:0]  out_tag
`ifdef KS_OVF_EN
    ,
    output logic                  out_ovf
`endif
);

    localparam int W      = DATA_WIDTH;
    localparam int LPS    = LEVELS_PER_STAGE;
    localparam int LEVELS = ks_levels(W);
    localparam int PS     = ks_prefix_stages(W, LPS);

    // Register stage 0 holds raw g/p; stage s+1 holds g/p after prefix stage s
    gp_t  [W-1:0]         gp_q  [0:PS];
    logic [W-1:0]         p0_q  [0:PS];
    logic [TAG_WIDTH-1:0] tag_q [0:PS];
    logic [PS:0]          cin_q;
    logic [PS:0]          vld_q;
    logic [PS:0]          load;
    logic                 load_out;

    gp_t  [W-1:0]         gp_in;
    gp_t  [W-1:0]         gp_d  [1:PS];
    logic [W-1:0]         b_eff;
    logic                 cin_eff;
    logic [W-1:0]         carry;
    logic [W:0]           sum_d;

    // Front end: subtract is A + ~B + 1, so cin is forced high and B inverted
    always_comb begin
        b_eff   = in_sub ? ~in_b : in_b;
        cin_eff = in_sub | in_cin;
        gp_in   = '0;
        for (int i = 0; i < W; i++) begin
            gp_in[i].g = in_a[i] & b_eff[i];
            gp_in[i].p = in_a[i] ^ b_eff[i];
        end
    end

    // Prefix network: stage s covers levels s*LPS .. s*LPS+LPS-1, span 2^k at level k
    for (genvar s = 0; s < PS; s++) begin : g_stage
        logic [W-1:0] g_src, p_src;
        for (genvar i = 0; i < W; i++) begin : g_unpack
            assign g_src[i] = gp_q[s][i].g;
            assign p_src[i] = gp_q[s][i].p;
        end
        for (genvar l = 0; l < LPS; l++) begin : g_level
            localparam int K = s * LPS + l;
            logic [W-1:0] gi, pi, go, po;
            if (l == 0) begin : g_from_reg
                assign gi = g_src;
                assign pi = p_src;
            end else begin : g_from_prev
                assign gi = g_level[l-1].go;
                assign pi = g_level[l-1].po;
            end
            for (genvar i = 0; i < W; i++) begin : g_bit
                if (K < LEVELS && i >= (1 << K)) begin : g_dot
                    ks_prefix_cell u_cell (
                        .g_hi (gi[i]),
                        .p_hi (pi[i]),
                        .g_lo (gi[i-(1<<K)]),
                        .p_lo (pi[i-(1<<K)]),
                        .g    (go[i]),
                        .p    (po[i])
                    );
                end else begin : g_pass
                    assign go[i] = gi[i];
                    assign po[i] = pi[i];
                end
            end
        end
        for (genvar i = 0; i < W; i++) begin : g_pack
            assign gp_d[s+1][i] = '{g: g_level[LPS-1].go[i], p: g_level[LPS-1].po[i]};
        end
    end

    // Ready chain: a stage loads when empty or when its successor loads this cycle
    always_comb begin
        load     = '0;
        load_out = !out_valid || out_ready;
        load[PS] = !vld_q[PS] || load_out;
        for (int s = PS - 1; s >= 0; s--) begin
            load[s] = !vld_q[s] || load[s+1];
        end
    end

    assign in_ready = load[0];

    // Pipeline registers; data only moves when a valid operation moves with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cin_q <= '0;
            for (int s = 0; s <= PS; s++) begin
                gp_q[s]  <= '0;
                p0_q[s]  <= '0;
                tag_q[s] <= '0;
            end
        end else begin
            if (load[0]) begin
                vld_q[0] <= in_valid;
                if (in_valid) begin
                    gp_q[0]  <= gp_in;
                    p0_q[0]  <= in_a ^ b_eff;
                    cin_q[0] <= cin_eff;
                    tag_q[0] <= in_tag;
                end
            end
            for (int s = 1; s <= PS; s++) begin
                if (load[s]) begin
                    vld_q[s] <= vld_q[s-1];
                    if (vld_q[s-1]) begin
                        gp_q[s]  <= gp_d[s];
                        p0_q[s]  <= p0_q[s-1];
                        cin_q[s] <= cin_q[s-1];
                        tag_q[s] <= tag_q[s-1];
                    end
                end
            end
        end
    end

    // Sum from full-span prefixes: C[i] = G[0:i] | (P[0:i] & cin)
    always_comb begin
        carry = '0;
        for (int i = 0; i < W; i++) begin
            carry[i] = gp_q[PS][i].g | (gp_q[PS][i].p & cin_q[PS]);
        end
        sum_d = {carry[W-1], p0_q[PS] ^ {carry[W-2:0], cin_q[PS]}};
    end

    // Output register; held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_tag   <= '0;
`ifdef KS_OVF_EN
            out_ovf   <= 1'b0;
`endif
        end else if (load_out) begin
            out_valid <= vld_q[PS];
            if (vld_q[PS]) begin
                out_sum <= sum_d;
                out_tag <= tag_q[PS];
`ifdef KS_OVF_EN
                out_ovf <= carry[W-1] ^ carry[W-2];
`endif
            end
        end
    end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// tb/tb_ks_adder_pipe.sv - directed self-checking bench for ks_adder_pipe (32-bit default and 13-bit/1-level builds)
module tb_ks_adder_pipe;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, in_cin, in_sub;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag, out_tag;
    logic        out_valid, out_ready;
    logic [32:0] out_sum;
`ifdef KS_OVF_EN
    logic        out_ovf;
`endif

    logic        s_in_valid, s_in_ready, s_in_cin, s_in_sub;
    logic [12:0] s_in_a, s_in_b;
    logic [3:0]  s_in_tag, s_out_tag;
    logic        s_out_valid, s_out_ready;
    logic [13:0] s_out_sum;
`ifdef KS_OVF_EN
    logic        s_out_ovf;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    ks_adder_pipe #(.DATA_WIDTH(32), .LEVELS_PER_STAGE(2), .TAG_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_tag(out_tag)
`ifdef KS_OVF_EN
        , .out_ovf(out_ovf)
`endif
    );

    ks_adder_pipe #(.DATA_WIDTH(13), .LEVELS_PER_STAGE(1), .TAG_WIDTH(4)) dut13 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b),
        .in_cin(s_in_cin), .in_sub(s_in_sub), .in_tag(s_in_tag),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum), .out_tag(s_out_tag)
`ifdef KS_OVF_EN
        , .out_ovf(s_out_ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // One op on the 32-bit instance: expect the result exactly 4 edges after the accept edge
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic [3:0] tag,
                          input logic [32:0] exp_sum, input logic exp_ovf);
        int lat;
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_tag = tag;
        out_ready = 1'b1;
        #1;
        check({name, "_rdy"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
        check({name, "_lat"}, 64'(lat), 64'd4);
        check({name, "_sum"}, 64'(out_sum), 64'(exp_sum));
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
`ifdef KS_OVF_EN
        check({name, "_ovf"}, 64'(out_ovf), 64'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("unexpected X ovf for %s", name);
`endif
    endtask

    // One op on the 13-bit, one-level-per-stage instance: latency 5
    task automatic run13(input string name, input logic [12:0] a, input logic [12:0] b,
                         input logic cin, input logic sub, input logic [3:0] tag,
                         input logic [13:0] exp_sum);
        int lat;
        s_in_valid = 1'b1; s_in_a = a; s_in_b = b; s_in_cin = cin; s_in_sub = sub; s_in_tag = tag;
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!s_out_valid && lat < 20);
        check({name, "_lat"}, 64'(lat), 64'd5);
        check({name, "_sum"}, 64'(s_out_sum), 64'(exp_sum));
        check({name, "_tag"}, 64'(s_out_tag), 64'(tag));
    endtask

    int accepted;
    int popped;
    int ghosts;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_tag = '0;
        out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_cin = 1'b0; s_in_sub = 1'b0; s_in_tag = '0;
        s_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum",   64'(out_sum),   64'd0);
        check("rst_out_tag",   64'(out_tag),   64'd0);
        check("rst13_valid",   64'(s_out_valid), 64'd0);
        rst_n = 1'b1;

        run_op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h1, 33'h1_0000_0000, 1'b0);
        run_op("sub_neg",   32'd5,         32'd7,         1'b0, 1'b1, 4'h2, 33'h0_FFFF_FFFE, 1'b0);
        run_op("sub_pos",   32'd7,         32'd5,         1'b0, 1'b1, 4'h3, 33'h1_0000_0002, 1'b0);
        run_op("add_cin",   32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 4'h4, 33'h0_2345_678A, 1'b0);
        run_op("sub_igcin", 32'd10,        32'd3,         1'b1, 1'b1, 4'h5, 33'h1_0000_0007, 1'b0);
        run_op("add_msb",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 4'h6, 33'h1_0000_0000, 1'b1);
        run_op("add_ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'h7, 33'h1_FFFF_FFFF, 1'b0);
        run_op("sub_eq",    32'd9,         32'd9,         1'b0, 1'b1, 4'h8, 33'h1_0000_0000, 1'b0);
        run_op("ovf_add",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h9, 33'h0_8000_0000, 1'b1);
        run_op("ovf_sub",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'hA, 33'h1_7FFF_FFFF, 1'b1);
        run_op("no_ovf",    32'd3,         32'd4,         1'b0, 1'b0, 4'hB, 33'h0_0000_0007, 1'b0);

        // Back-pressure: consumer stalled for 10 cycles while 8 ops are offered
        @(posedge clk); #1;
        out_ready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 10; c++) begin
            if (accepted < 8) begin
                in_valid = 1'b1; in_a = 32'(accepted) << 4; in_b = 32'd1;
                in_cin = 1'b0; in_sub = 1'b0; in_tag = 4'(accepted);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) accepted++;
            @(posedge clk); #1;
        end
        check("bp_accepted",  64'(accepted),  64'd5);
        check("bp_in_ready",  64'(in_ready),  64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_hold_sum",  64'(out_sum),   64'd1);
        check("bp_hold_tag",  64'(out_tag),   64'd0);

        out_ready = 1'b1;
        popped = 0;
        for (int c = 0; c < 8; c++) begin
            if (accepted < 8) begin
                in_valid = 1'b1; in_a = 32'(accepted) << 4; in_b = 32'd1;
                in_cin = 1'b0; in_sub = 1'b0; in_tag = 4'(accepted);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 0) check("bp_push_pop_ready", 64'(in_ready), 64'd1);
            if (out_valid) begin
                check("bp_order_tag", 64'(out_tag), 64'(popped));
                check("bp_order_sum", 64'(out_sum), 64'((popped << 4) + 1));
                popped++;
            end
            if (in_valid && in_ready) accepted++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_drained", 64'(popped), 64'd8);
        check("bp_empty",   64'(out_valid), 64'd0);

        // Reset while three ops are in flight
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_a = 32'(c); in_b = 32'(c); in_cin = 1'b0; in_sub = 1'b0;
            in_tag = 4'(9 + c);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("rst_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_sum",   64'(out_sum),   64'd0);
        check("rst_mid_tag",   64'(out_tag),   64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ghosts = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid) ghosts++;
        end
        check("rst_no_ghost", 64'(ghosts), 64'd0);

        // Non-power-of-two width, one prefix level per stage
        run13("w13_wrap",   13'h1FFF, 13'h0001, 1'b0, 1'b0, 4'h1, 14'h2000);
        run13("w13_ones",   13'h1FFF, 13'h1FFF, 1'b1, 1'b0, 4'h2, 14'h3FFF);
        run13("w13_subneg", 13'd5,    13'd7,    1'b0, 1'b1, 4'h3, 14'h1FFE);
        run13("w13_subpos", 13'h1000, 13'h0001, 1'b1, 1'b1, 4'h4, 14'h2FFF);
        run13("w13_cin",    13'h0ABC, 13'h0123, 1'b1, 1'b0, 4'h5, 14'h0BE0);
        run13("w13_subeq",  13'h1234, 13'h1234, 1'b0, 1'b1, 4'h6, 14'h2000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
